// File: rtl/srv_ifill.sv
// srv_ifill: schoolRISCV I-cache line-fill engine; reads a 4-word line as sequential bus beats.
// Define SRV_IFILL_LINEBUF_EN to add a single-entry line buffer that answers repeat requests.
module srv_ifill #(
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_i,
    input  logic [31:0]              addr_i,
    output logic                     rsp_o,
    output logic [LINE_WORDS*32-1:0] data_o,
    output logic                     busy_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE, COOL} state_e;

    state_e                   state_q, state_d;
    logic [29:0]              base_q, base_d;
    logic [1:0]               beat_q, beat_d;
    logic [LINE_WORDS*32-1:0] data_q, data_d;
    logic                     beat_ack;
    logic                     fill_done;
    logic                     buf_hit;
    logic                     unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign beat_ack    = (state_q == FETCH) && mem_ack_i;
    assign fill_done   = beat_ack && (beat_q == 2'd3);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its pre-edge inputs, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = buf_hit ? DONE : FETCH;
            FETCH:   if (fill_done) state_d = DONE;
            DONE:    state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = 1'b0;
        rsp_o     = 1'b0;
        busy_o    = 1'b1;
        case (state_q)
            IDLE:    busy_o    = 1'b0;
            FETCH:   mem_req_o = 1'b1;
            DONE:    rsp_o     = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        base_d = base_q;
        beat_d = beat_q;
        data_d = data_q;
        if ((state_q == IDLE) && req_i) begin
            base_d = addr_i[31:2];
            beat_d = 2'd0;
        end
        // The 2-bit counter wraps 3->0 on the final beat.
        if (beat_ack) begin
            data_d[{beat_q, 5'd0} +: 32] = mem_rdata_i;
            beat_d                       = beat_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            beat_q <= '0;
            data_q <= '0;
        end else begin
            base_q <= base_d;
            beat_q <= beat_d;
            data_q <= data_d;
        end
    end

    // Line addresses never carry out of the beat field.
    assign mem_addr_o = {base_q, beat_q};
    assign data_o     = data_q;

`ifdef SRV_IFILL_LINEBUF_EN
    // data_q always holds the last completed line while valid_q is set, so it doubles as buffer data.
    logic [29:0] tag_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (fill_done) begin
            tag_q   <= base_q;
            valid_q <= 1'b1;
        end
    end

    assign buf_hit = valid_q && (tag_q == addr_i[31:2]);
`else
    assign buf_hit = 1'b0;
`endif

endmodule

// File: tb/tb_srv_ifill.sv
// Directed bench for srv_ifill: zero/multi-wait fills, request drop/hold, spurious acks,
// mid-fill reset and repeat requests (buffer hit when SRV_IFILL_LINEBUF_EN is defined).
module tb_srv_ifill;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic         rsp_o;
    logic [127:0] data_o;
    logic         busy_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ack_i = 1'b0;
    logic [31:0]  mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    srv_ifill dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .rsp_o       (rsp_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; issues the request there so the next
    // rising edge is T. Cycle c is the cycle following edge T+c-1. Returns at the falling
    // edge of cycle exp_rsp+2, the first IDLE cycle after COOL.
    task automatic run_fill(input string tag, input logic [31:0] addr, input logic [31:0] exp_base,
                            input int waits, input logic [127:0] line, input int drop_at,
                            input int exp_beats, input int exp_rsp);
        int beat, wcnt, req_cycles, rsp_cnt, rsp_at;
        logic [31:0] exp_addr;
        beat = 0; wcnt = 0; req_cycles = 0; rsp_cnt = 0; rsp_at = 0;
        req_i     = 1'b1;
        addr_i    = addr;
        mem_ack_i = 1'b0;
        for (int c = 1; c <= exp_rsp + 2; c++) begin
            @(negedge clk);
            req_i       = (c < drop_at);
            addr_i      = 32'hFFFF_FFFF;
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_0000 + 32'(c);
            if (mem_req_o) begin
                req_cycles++;
                if (beat < 4) begin
                    exp_addr = {exp_base[31:2], 2'(beat)};
                    check({tag, " mem_addr"}, 128'(mem_addr_o), 128'(exp_addr));
                    if (wcnt == waits) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = line[beat*32 +: 32];
                        beat++;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                mem_ack_i = 1'b1;
            end
            if (rsp_o) begin
                rsp_cnt++;
                rsp_at = c;
                check({tag, " data_at_rsp"}, data_o, line);
                check({tag, " busy_at_rsp"}, 128'(busy_o), 128'(1));
            end
            if (c == exp_rsp + 1) begin
                check({tag, " busy_cool"}, 128'(busy_o), 128'(1));
                check({tag, " data_cool"}, data_o, line);
            end
            if (c == exp_rsp + 2) begin
                check({tag, " busy_idle"}, 128'(busy_o), 128'(0));
            end
        end
        mem_ack_i = 1'b0;
        check({tag, " rsp_count"}, 128'(rsp_cnt), 128'(1));
        check({tag, " rsp_cycle"}, 128'(rsp_at), 128'(exp_rsp));
        check({tag, " beats"}, 128'(beat), 128'(exp_beats));
        check({tag, " req_cycles"}, 128'(req_cycles), 128'(exp_beats * (waits + 1)));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset rsp", 128'(rsp_o), 128'(0));
        check("reset busy", 128'(busy_o), 128'(0));
        check("reset mem_req", 128'(mem_req_o), 128'(0));
        check("reset mem_addr", 128'(mem_addr_o), 128'(0));
        check("reset data", data_o, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_fill("zero_wait", 32'h0000_0104, 32'h0000_0104, 0,
                 128'h00000044_00000033_00000022_00000011, 1, 4, 5);
        run_fill("wait2", 32'h0000_0304, 32'h0000_0304, 2,
                 128'hA0000004_A0000003_A0000002_A0000001, 1, 4, 13);
        run_fill("drop_after_ack", 32'h0000_040B, 32'h0000_0408, 0,
                 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1, 2, 4, 5);
        run_fill("held_req", 32'h0000_0500, 32'h0000_0500, 0,
                 128'hC0000044_C0000033_C0000022_C0000011, 1000, 4, 5);
        run_fill("after_held", 32'h0000_0604, 32'h0000_0604, 0,
                 128'hD0000044_D0000033_D0000022_D0000011, 1, 4, 5);

        req_i  = 1'b1;
        addr_i = 32'h0000_0700;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            req_i       = 1'b0;
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hCAFE_0000 + 32'(c);
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("pre_reset mem_req", 128'(mem_req_o), 128'(1));
        check("pre_reset mem_addr", 128'(mem_addr_o), 128'(32'h0000_0702));
        rst_n = 1'b0;
        #1;
        check("mid_reset mem_req", 128'(mem_req_o), 128'(0));
        check("mid_reset busy", 128'(busy_o), 128'(0));
        check("mid_reset mem_addr", 128'(mem_addr_o), 128'(0));
        check("mid_reset data", data_o, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_fill("refetch", 32'h0000_0700, 32'h0000_0700, 0,
                 128'hE0000044_E0000033_E0000022_E0000011, 1, 4, 5);
`ifdef SRV_IFILL_LINEBUF_EN
        run_fill("repeat_hit", 32'h0000_0702, 32'h0000_0700, 0,
                 128'hE0000044_E0000033_E0000022_E0000011, 1, 0, 1);
`else
        run_fill("repeat_fill", 32'h0000_0702, 32'h0000_0700, 0,
                 128'hF0000044_F0000033_F0000022_F0000011, 1, 4, 5);
`endif
        run_fill("next_line", 32'h0000_0708, 32'h0000_0708, 0,
                 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 1, 4, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/srv_ifill.md
# srv_ifill

Instruction line-fill engine between the schoolRISCV L1 instruction cache and the 32-bit instruction memory bus. It accepts a line request from the cache's external port and fetches the four 32-bit words of the 128-bit line as sequential single-word bus transactions. It returns the assembled line with a one-cycle response pulse. All addresses are word addresses; a line is 4 words aligned on addr[1:0] = 0.

## Interface
- LINE_WORDS, 4, words per line; only 4 is supported (data_o 128 bits, beat counter 2 bits).
- clk  input  1  clock, all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_i  input  1  line request from the cache (level); sampled only in IDLE
- addr_i  input  32  word address of the line base; bits [1:0] ignored and treated as 0
- rsp_o  output  1  one-cycle pulse; line in data_o is valid in this cycle
- data_o  output  128  assembled line; word k in bits [32k+31:32k]
- busy_o  output  1  high in every state except IDLE
- mem_req_o  output  1  bus read request, held until acknowledged
- mem_addr_o  output  32  bus word address, stable while mem_req_o is high and not yet acked
- mem_ack_i  input  1  bus acknowledge; completes the current beat
- mem_rdata_i  input  32  read data, valid in the mem_ack_i cycle

## Operation
- States: IDLE, FETCH, DONE, COOL.
- IDLE:
  - req_i=1 latches base = {addr_i[31:2],2'b00} and clears beat counter to 0 -> FETCH.
- FETCH:
  - mem_req_o=1, mem_addr_o = base + beat.
  - On mem_ack_i: store mem_rdata_i into line word[beat], beat++.
  - On the ack of beat 3 -> DONE.
  - The next beat's request follows in the cycle after an ack; mem_req_o stays high across beats.
- DONE: rsp_o=1 for exactly one cycle, data_o holds the full line -> COOL.
- COOL: one cycle in which req_i is ignored (absorbs the cache's request lag) -> IDLE.
- data_o is registered and holds its last line until the next fill overwrites it word by word.
- Address arithmetic is only over bits [1:0]: base+beat never carries into bit 2. Beat counter wraps 3->0 on completion.
- Boundary conditions:
  - req_i deasserted mid-fill: the fill completes and rsp_o still pulses; no abort.
  - mem_ack_i while mem_req_o=0 (IDLE/DONE/COOL): ignored, no data captured.
  - mem_ack_i held high continuously: one beat per cycle.
  - addr_i changing during FETCH: ignored; base stays latched.
  - Reset mid-fill: state goes to IDLE immediately (asynchronous); the partial line is discarded; mem_req_o drops without waiting for ack.

## Timing
- Reset values: rsp_o=0, busy_o=0, mem_req_o=0, mem_addr_o=0, data_o=0, beat=0, state IDLE.
- req_i sampled at edge T -> mem_req_o high from T+1.
- With zero-wait memory (ack every cycle): acks at T+1..T+4, rsp_o at T+5, COOL at T+6, IDLE accepts a new request at edge T+7.
- With W wait cycles per beat: rsp_o at T+1+4(W+1).
- busy_o is high from T+1 through the COOL cycle.

## Configuration
- SRV_IFILL_LINEBUF_EN defined:
  - Adds a single-entry line buffer (tag = base[31:2] plus a valid bit, data = last completed line).
  - In IDLE, a req_i whose base matches a valid tag goes directly to DONE without any bus traffic: rsp_o at T+1 with the buffered line.
  - Tag and valid bit are written on every completed fill.
  - Reset clears the valid bit. A reset mid-fill leaves the previous buffer contents invalid.
- SRV_IFILL_LINEBUF_EN not defined:
  - No buffer is built; every request performs a 4-beat bus fill.

## Test plan
- Reset, then req_i=1 with addr_i=0x0000_0104 and zero-wait memory returning 0x11,0x22,0x33,0x44 -> mem_addr_o 0x104,0x105,0x106,0x107; rsp_o at T+5; data_o=0x00000044_00000033_00000022_00000011.
- Same request with 2 wait cycles per beat -> rsp_o at T+13; each mem_addr_o is stable while unacked.
- req_i dropped after the first ack -> remaining 3 beats are still issued; exactly one rsp_o pulse.
- req_i held high through DONE/COOL -> second fill starts only at edge T+7; no duplicate beat issued in COOL.
- rst_n asserted after 2 acks -> mem_req_o=0 and busy_o=0 immediately; the next request refetches from beat 0.
- With SRV_IFILL_LINEBUF_EN: a repeat request to 0x104 gives rsp_o at T+1 with mem_req_o never asserted; a request to 0x108 performs a bus fill.
